// File: rtl/if_fetch_seq.sv
// if_fetch_seq: fetch-stage sequencer. Owns the PC, issues req/ack fetches to
// imem, fills the IF/ID slot (plus a one-entry skid buffer for an ack that
// lands while the slot is stalled) and arbitrates redirect > stall > advance.
// Optional feature macro: IF_FETCH_TIMEOUT_EN (ack timeout with fetch_err pulse).
module if_fetch_seq #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          BOOT_DELAY     = 2,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        flush
`ifdef IF_FETCH_TIMEOUT_EN
  ,output logic       fetch_err
`endif
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_HOLD} state_t;

  // Reject out-of-range configurations at elaboration time.
  if (BOOT_DELAY < 1 || BOOT_DELAY > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("if_fetch_seq: BOOT_DELAY must be 1..15 and TIMEOUT_CYCLES >= 1");
  end

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_boot_cnt;
  logic [31:0] r_pc;
  logic        r_drop;       // outstanding request was overtaken by a redirect
  logic [31:0] r_daddr;      // address of that overtaken request
  logic        r_vld;
  logic [31:0] r_inst, r_ipc;
  logic        r_sk_vld;
  logic [31:0] r_sk_inst, r_sk_pc;
  logic        r_flush;
  logic        w_req, w_ack, w_take, w_consume, w_gap;

`ifdef IF_FETCH_TIMEOUT_EN
  logic [31:0] r_tcnt;
  logic        r_gap;        // one-cycle request gap after a timeout
  logic        r_ferr;
  logic        w_tout;
  assign w_gap     = r_gap;
  assign w_tout    = w_req && !imem_ack && (r_tcnt == 32'(TIMEOUT_CYCLES - 1));
  assign fetch_err = r_ferr;

  // Timeout counter: counts unacked request cycles, opens a one-cycle gap at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
      r_gap  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_gap  <= w_tout;
      r_ferr <= w_tout;
      if (w_tout || w_ack || !w_req) r_tcnt <= '0;
      else                           r_tcnt <= r_tcnt + 32'd1;
    end
  end
`else
  assign w_gap = 1'b0;
`endif

  assign w_req     = (r_state == S_REQ) && !w_gap;
  assign w_ack     = w_req && imem_ack;
  assign w_take    = w_ack && !r_drop && !redirect_valid;
  assign w_consume = r_vld && !stall;

  assign pc        = r_pc;
  assign imem_req  = w_req;
  assign imem_addr = r_drop ? r_daddr : r_pc;
  assign if_valid  = r_vld;
  assign if_inst   = r_inst;
  assign if_pc     = r_ipc;
  assign flush     = r_flush;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_BOOT;
    else        r_state <= w_state_nxt;
  end

  // Next-state: boot countdown, park in HOLD after an ack under stall, redirect wakes HOLD.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_BOOT: if (r_boot_cnt == 4'(BOOT_DELAY - 1)) w_state_nxt = S_REQ;
      S_REQ:  if (w_take && stall)                  w_state_nxt = S_HOLD;
      S_HOLD: if (redirect_valid || !stall)         w_state_nxt = S_REQ;
      default:                                      w_state_nxt = S_BOOT;
    endcase
  end

  // PC, drop tracking, boot counter and flush pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_boot_cnt <= '0;
      r_drop     <= 1'b0;
      r_daddr    <= RESET_PC;
      r_flush    <= 1'b0;
    end else begin
      r_flush <= redirect_valid;
      if (r_state == S_BOOT) r_boot_cnt <= r_boot_cnt + 4'd1;
      if (redirect_valid)    r_pc <= redirect_target;
      else if (w_take)       r_pc <= npc_in;
      if (w_ack) begin
        r_drop <= 1'b0;
      end else if (redirect_valid && w_req) begin
        r_drop <= 1'b1;
        if (!r_drop) r_daddr <= r_pc;
      end
`ifdef IF_FETCH_TIMEOUT_EN
      if (w_tout) r_drop <= 1'b0;
`endif
    end
  end

  // IF/ID slot and skid buffer: redirect empties both; consumption refills from skid or ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld     <= 1'b0;
      r_inst    <= '0;
      r_ipc     <= '0;
      r_sk_vld  <= 1'b0;
      r_sk_inst <= '0;
      r_sk_pc   <= '0;
    end else if (redirect_valid) begin
      r_vld    <= 1'b0;
      r_sk_vld <= 1'b0;
    end else if (w_consume) begin
      if (r_sk_vld) begin
        r_inst   <= r_sk_inst;
        r_ipc    <= r_sk_pc;
        r_sk_vld <= 1'b0;
      end else if (w_take) begin
        r_inst <= imem_rdata;
        r_ipc  <= imem_addr;
      end else begin
        r_vld <= 1'b0;
      end
    end else if (w_take) begin
      if (r_vld) begin
        r_sk_inst <= imem_rdata;
        r_sk_pc   <= imem_addr;
        r_sk_vld  <= 1'b1;
      end else begin
        r_inst <= imem_rdata;
        r_ipc  <= imem_addr;
        r_vld  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/if_fetch_seq.md
Name: if_fetch_seq

Overview:
- Fetch-stage sequencer. Owns the architectural PC register and drives it to the next-PC unit (`pc` out, `npc_in` back).
- Issues requests to instruction memory using a req/ack handshake and fills the IF/ID slot.
- Arbitrates between three events: sequential advance, redirects resolved in EX, and hazard-unit stalls.
- Sits between the next-PC unit, imem and the IF/ID boundary.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- BOOT_DELAY, 2: idle cycles after reset release before the first request (1..15).
- TIMEOUT_CYCLES, 16: ack timeout. Used only with the optional feature.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- npc_in, input, 32: next PC from the next-PC unit, computed from `pc`.
- redirect_valid, input, 1: EX resolved a taken branch or jump.
- redirect_target, input, 32: redirect destination.
- stall, input, 1: hazard unit; ID does not accept the IF/ID slot this cycle.
- imem_ack, input, 1: imem returns data for the outstanding request.
- imem_rdata, input, 32: instruction word, valid with imem_ack.
- pc, output, 32: current fetch PC, to the next-PC unit.
- imem_req, output, 1: fetch request.
- imem_addr, output, 32: fetch address.
- if_valid, output, 1: IF/ID slot holds a valid instruction.
- if_inst, output, 32: instruction in the slot.
- if_pc, output, 32: PC of the slot instruction.
- flush, output, 1: one-cycle pulse that kills younger stages after a redirect.

Behaviour:
- Reset (asynchronous, any state):
  - pc = RESET_PC.
  - state = BOOT, boot counter = 0, drop = 0.
  - imem_req = 0, imem_addr = RESET_PC.
  - if_valid = 0, if_inst = 0, if_pc = 0, flush = 0.
- States: BOOT, REQ, HOLD.
  - **BOOT:** the counter increments each cycle. When it reaches BOOT_DELAY-1, go to REQ. imem_req = 0.
  - **REQ:** imem_req = 1 and imem_addr = pc, both held stable until imem_ack.
    - On ack with drop = 0: if_inst <= imem_rdata, if_pc <= pc, if_valid <= 1, pc <= npc_in.
    - After that accepted ack, stay in REQ if stall = 0; go to HOLD if stall = 1.
    - On ack with drop = 1: discard the data, clear drop, start a new request at the redirected pc next cycle.
  - **HOLD:** imem_req = 0, and the slot is held unchanged. When stall = 0, the slot is consumed this cycle; go to REQ.
- Slot consumption: the slot is consumed on any cycle with if_valid && !stall. If no new ack lands in that cycle, if_valid <= 0 next cycle.
- Fetch latency: min 1 cycle from imem_req to if_valid when imem acks in the same cycle. Throughput is 1 instr/cycle with zero-wait imem and no stall.
- Redirect has highest priority in every state, including over stall:
  - pc <= redirect_target, if_valid <= 0, flush <= 1 for exactly one cycle.
  - Redirect in REQ with no ack this cycle: the request is still outstanding, so set drop = 1. imem_addr keeps the old address until ack.
  - Redirect in the same cycle as ack: the acked word is discarded, drop stays 0, and the new request issues next cycle.
  - Redirect in HOLD: go to REQ next cycle.
  - Redirect in BOOT: pc updates and the boot count continues.
  - Back-to-back redirects: the last target wins, drop stays 1, and flush stays high for each cycle carrying a redirect.
- Stall with no slot occupied has no effect on fetching.
- Stall in REQ while the slot is occupied and unconsumed: the outstanding request completes, but no ack may overwrite the valid slot. The ack is buffered in a one-entry skid register, moved into the slot when consumed, and the FSM goes to HOLD.
- Arithmetic: PC is 32-bit with no alignment check. Wrap-around from 0xFFFF_FFFC is whatever npc_in supplies.

Optional Feature:
- Macro: IF_FETCH_TIMEOUT_EN.
- When defined:
  - A counter runs while in REQ without ack.
  - At TIMEOUT_CYCLES it drops imem_req for one cycle, then re-issues at the same address.
  - Output port fetch_err (1 bit) pulses for one cycle. A late ack from the abandoned request is ignored.
- When undefined: the counter and fetch_err are absent, and REQ waits indefinitely.

Test Plan:
- Reset release, BOOT_DELAY = 2, imem acks same cycle with `npc_in = pc + 4`:
  - First imem_req appears at cycle 2 with addr 0x0.
  - if_pc sequence 0x0, 0x4, 0x8 on consecutive cycles.
- Stall = 1 for 3 cycles with if_pc = 0x8 in the slot:
  - if_inst and if_pc hold.
  - No more than one further ack is accepted.
  - After the stall drops, the next slot is if_pc = 0xC and no instruction is lost.
- Redirect to 0x100 while a request to 0x10 is outstanding and ack arrives 2 cycles later:
  - flush is high for 1 cycle and the 0x10 data is discarded.
  - Next imem_addr = 0x100, then if_pc = 0x100.
- redirect_valid in the same cycle as an ack for 0x20, target 0x40:
  - if_valid = 0 next cycle.
  - The next request is 0x40 with no extra dropped ack.
- Assert rst_n low mid-REQ with imem_req = 1:
  - Outputs return to reset values immediately, without waiting for a clock edge.
  - Refetch starts at RESET_PC after BOOT_DELAY.
- With IF_FETCH_TIMEOUT_EN and TIMEOUT_CYCLES = 16, withhold ack:
  - fetch_err pulses at cycle 16.
  - imem_req deasserts for 1 cycle, then reissues at the same address.
